// File: rtl/arbitro_mux_8x1_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter in front of mux_8x1_n.
package arbitro_pkg;
  localparam int N_ENTRADAS = 8;
  localparam int SEL_W      = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CONCEDE = 2'b01,
    TROCA   = 2'b10
  } estado_t;
endpackage

// File: rtl/arbitro_mux_8x1_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arbitro_mux_8x1_if;
  import arbitro_pkg::*;

  logic [N_ENTRADAS-1:0] REQ;
  logic [N_ENTRADAS-1:0] GNT;
  logic [SEL_W-1:0]      SEL;
  logic                  VALIDO;
  logic [1:0]            ESTADO_DB;

  modport master (output REQ, input GNT, SEL, VALIDO, ESTADO_DB);
  modport slave  (input REQ, output GNT, SEL, VALIDO, ESTADO_DB);
endinterface

// File: rtl/arbitro_mux_8x1_seletor_prioridade_rr.sv
// Combinational circular priority encoder: first set REQ bit scanning upward from ptr, wrapping at 7.
module seletor_prioridade_rr
  import arbitro_pkg::*;
(
  input  logic [N_ENTRADAS-1:0] REQ,
  input  logic [SEL_W-1:0]      ptr,
  output logic [SEL_W-1:0]      indice,
  output logic                  achou
);

  logic [SEL_W-1:0] w_cand;

  // Walk from the farthest offset down so the closest hit to ptr is written last and wins.
  always_comb begin
    indice = '0;
    achou  = 1'b0;
    w_cand = ptr;
    for (int k = N_ENTRADAS - 1; k >= 0; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (REQ[w_cand]) begin
        indice = w_cand;
        achou  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux_8x1.sv
// Round-robin arbiter driving the mux_8x1_n select, with a bounded grant length under contention.
module arbitro_mux_8x1
  import arbitro_pkg::*;
#(
  parameter int MAX_CICLOS = 16
) (
  input  logic               clock,
  input  logic               reset,
  arbitro_mux_8x1_if.slave   bus
);

  localparam int              CNT_W   = $clog2(MAX_CICLOS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CICLOS - 1);

  estado_t               r_estado, w_estado_nxt;
  logic [N_ENTRADAS-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0]      r_sel, w_sel_nxt;
  logic                  r_valido, w_valido_nxt;
  logic [SEL_W-1:0]      r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

  logic [SEL_W-1:0]      w_indice;
  logic                  w_achou;
  logic                  w_outros;
  logic                  w_limite;

  seletor_prioridade_rr u_seletor (
    .REQ    (bus.REQ),
    .ptr    (r_ptr),
    .indice (w_indice),
    .achou  (w_achou)
  );

  assign w_outros = |(bus.REQ & ~r_gnt);
  assign w_limite = (r_cnt == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_gnt    <= '0;
      r_sel    <= '0;
      r_valido <= 1'b0;
      r_ptr    <= '0;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_nxt;
      r_gnt    <= w_gnt_nxt;
      r_sel    <= w_sel_nxt;
      r_valido <= w_valido_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_gnt_nxt    = r_gnt;
    w_sel_nxt    = r_sel;
    w_valido_nxt = r_valido;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    case (r_estado)
      OCIOSO, TROCA: begin
        w_estado_nxt = OCIOSO;
        w_gnt_nxt    = '0;
        w_valido_nxt = 1'b0;
        if (w_achou) begin
          w_estado_nxt = CONCEDE;
          w_gnt_nxt    = {{(N_ENTRADAS-1){1'b0}}, 1'b1} << w_indice;
          w_sel_nxt    = w_indice;
          w_valido_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      CONCEDE: begin
        // Release and preemption share one exit; SEL is kept so the mux select stays stable.
        if (!bus.REQ[r_sel] || (w_limite && w_outros)) begin
          w_estado_nxt = TROCA;
          w_gnt_nxt    = '0;
          w_valido_nxt = 1'b0;
          w_ptr_nxt    = r_sel + SEL_W'(1);
        end else if (!w_limite) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_estado_nxt = OCIOSO;
        w_gnt_nxt    = '0;
        w_valido_nxt = 1'b0;
      end
    endcase
  end

  assign bus.GNT       = r_gnt;
  assign bus.SEL       = r_sel;
  assign bus.VALIDO    = r_valido;
  assign bus.ESTADO_DB = r_estado;

endmodule

// File: tb/tb_arbitro_mux_8x1.sv
// Bench for arbitro_mux_8x1: directed scenarios plus random traffic against an owner/pointer model.
module tb_arbitro_mux_8x1;
  localparam int MAXC = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_erros  = 0;

  arbitro_mux_8x1_if bus();

  arbitro_mux_8x1 #(.MAX_CICLOS(MAXC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: who owns the mux, for how many cycles, where the search starts, and whether a gap is showing.
  int m_dono, m_sel, m_ptr, m_tempo;
  bit m_troca;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_erros++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelo(input logic [7:0] req, input logic rst);
    bit outros;
    if (rst) begin
      m_dono = -1; m_sel = 0; m_ptr = 0; m_tempo = 0; m_troca = 0;
    end else if (m_dono >= 0) begin
      outros = 0;
      for (int i = 0; i < 8; i++) if (i != m_dono && req[i]) outros = 1;
      if (!req[m_dono] || (m_tempo >= MAXC && outros)) begin
        m_ptr   = (m_dono + 1) % 8;
        m_dono  = -1;
        m_troca = 1;
      end else begin
        m_tempo++;
      end
    end else begin
      m_troca = 0;
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (req[i] && m_dono < 0) begin
          m_dono = i; m_sel = i; m_tempo = 1;
        end
      end
    end
  endtask

  task automatic ciclo(input logic [7:0] req, input logic rst);
    logic [7:0] exp_gnt;
    @(negedge clock);
    bus.REQ = req;
    reset   = rst;
    @(posedge clock);
    modelo(req, rst);
    #1;
    exp_gnt = (m_dono >= 0) ? (8'd1 << m_dono) : 8'd0;
    chk("gnt",    bus.GNT,       exp_gnt);
    chk("sel",    bus.SEL,       m_sel);
    chk("valido", bus.VALIDO,    (m_dono >= 0) ? 1 : 0);
    chk("estado", bus.ESTADO_DB, (m_dono >= 0) ? 1 : (m_troca ? 2 : 0));
  endtask

  initial begin
    int n_val;
    int prox;
    bit v_ant;
    logic [7:0] r;
    bus.REQ = '0;

    // Reset and idle
    ciclo(8'h00, 1'b1);
    for (int c = 0; c < 10; c++) ciclo(8'h00, 1'b0);
    chk("t1_gnt", bus.GNT, 32'h0);
    chk("t1_estado", bus.ESTADO_DB, 32'h0);

    // Single request, then release into a one-cycle gap
    ciclo(8'h04, 1'b0);
    chk("t2_gnt", bus.GNT, 32'h04);
    chk("t2_sel", bus.SEL, 32'h2);
    ciclo(8'h04, 1'b0);
    ciclo(8'h00, 1'b0);
    chk("t2_gap_valido", bus.VALIDO, 32'h0);
    chk("t2_gap_sel", bus.SEL, 32'h2);
    chk("t2_gap_estado", bus.ESTADO_DB, 32'h2);
    ciclo(8'h00, 1'b0);
    chk("t2_ocioso", bus.ESTADO_DB, 32'h0);

    // All requesting: rotation 0..7,0 with 4-cycle grants and 1-cycle gaps
    ciclo(8'h00, 1'b1);
    n_val = 0; prox = 0; v_ant = 0;
    for (int c = 0; c < 41; c++) begin
      ciclo(8'hFF, 1'b0);
      if (c < 40 && bus.VALIDO === 1'b1) n_val++;
      if (bus.VALIDO === 1'b1 && !v_ant) begin
        chk("t3_ordem", bus.SEL, prox);
        prox = (prox + 1) % 8;
      end
      v_ant = (bus.VALIDO === 1'b1);
    end
    chk("t3_ciclos_validos", n_val, 32);
    chk("t3_grants", prox, 1);

    // Wrap from index 7 to 0
    ciclo(8'h00, 1'b1);
    ciclo(8'h80, 1'b0);
    ciclo(8'h80, 1'b0);
    chk("t4_gnt7", bus.GNT, 32'h80);
    ciclo(8'h00, 1'b0);
    ciclo(8'h81, 1'b0);
    chk("t4_gnt0", bus.GNT, 32'h01);
    chk("t4_sel0", bus.SEL, 32'h0);
    for (int c = 0; c < 5; c++) ciclo(8'h81, 1'b0);
    chk("t4_gnt7b", bus.GNT, 32'h80);

    // Sole requester keeps the grant without gaps
    ciclo(8'h00, 1'b1);
    n_val = 0;
    for (int c = 0; c < 40; c++) begin
      ciclo(8'h08, 1'b0);
      if (bus.GNT === 8'h08 && bus.VALIDO === 1'b1) n_val++;
    end
    chk("t5_continuo", n_val, 40);

    // Reset mid-grant restores ptr to 0
    ciclo(8'h00, 1'b1);
    ciclo(8'h20, 1'b0);
    ciclo(8'h21, 1'b0);
    ciclo(8'h21, 1'b0);
    chk("t6_gnt5", bus.GNT, 32'h20);
    ciclo(8'h21, 1'b1);
    chk("t6_rst_gnt", bus.GNT, 32'h0);
    chk("t6_rst_sel", bus.SEL, 32'h0);
    chk("t6_rst_valido", bus.VALIDO, 32'h0);
    ciclo(8'h21, 1'b0);
    chk("t6_gnt0", bus.GNT, 32'h01);

    // Random traffic with sticky requests and occasional resets
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) r = 8'($urandom);
      ciclo(r, ($urandom_range(0, 99) == 0));
      if (bus.VALIDO === 1'b1) chk("inv_gnt_sel", bus.GNT[bus.SEL], 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
    $finish;
  end

endmodule

// File: doc/arbitro_mux_8x1.md
Name: arbitro_mux_8x1

Overview:
- Round-robin arbiter that shares the 8-input datapath multiplexer (mux_8x1_n) among 8 requesters.
- Takes one request line per mux input, grants exactly one at a time, and drives the mux SEL with the granted index.
- Limits grant length when other requesters contend.
- Flags when the mux output holds valid granted data.

Parameters:
- MAX_CICLOS, 16, maximum grant length in cycles under contention (legal range 1..255).
- N_ENTRADAS, 8, number of requesters; fixed to the mux width, not overridable (package constant).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- REQ  in  8  request vector; bit i high = requester i wants mux input Di; held high for the whole transfer.
- GNT  out  8  one-hot grant, or all zeros; registered.
- SEL  out  3  mux select = index of current/last grant; registered.
- VALIDO  out  1  high while a grant is active (mux output carries granted data); registered.
- ESTADO_DB  out  2  current FSM state encoding, debug only.

Behaviour:
- Reset (synchronous, one edge): GNT=0, SEL=000, VALIDO=0, state OCIOSO, priority pointer ptr=0, hold counter cnt=0. Reset wins over every other event, including mid-grant.
- Selection: pick the first i with REQ[i]=1, scanning circularly from ptr: ptr, ptr+1, ..., 7, 0, ..., ptr-1.
- OCIOSO:
  - If REQ is nonzero, register the selected i: GNT=1<<i, SEL=i, VALIDO=1, cnt=0, go to CONCEDE.
  - Otherwise stay, outputs unchanged.
  - Latency: REQ high at edge k gives GNT at edge k+1.
- CONCEDE:
  - Release: if REQ[SEL]=0, go to TROCA.
  - Preempt: if cnt==MAX_CICLOS-1 and any other REQ bit is high, go to TROCA.
  - Sole requester: if cnt==MAX_CICLOS-1 and no other REQ bit is high, stay; cnt saturates; grant continues with no gap.
  - Otherwise stay and increment cnt.
  - Release and preempt in the same cycle are handled identically.
- TROCA (exactly one cycle):
  - GNT=0, VALIDO=0, SEL holds its last value.
  - ptr = SEL+1 mod 8; 7 wraps to 0.
  - At the next edge, arbitrate as in OCIOSO using the new ptr: go to CONCEDE with a new grant, or to OCIOSO if REQ=0.
  - Handoff gap between two grants is therefore exactly 1 cycle. The same requester may be re-granted after the gap if it is the only one requesting.
- Invariants: GNT is always zero or one-hot. GNT nonzero ⇔ VALIDO=1. When VALIDO=1, GNT[SEL]=1.
- cnt width is $clog2(MAX_CICLOS)+1. With MAX_CICLOS=1 every contended grant lasts one cycle.
- ESTADO_DB encoding: OCIOSO=00, CONCEDE=01, TROCA=10.

Decomposition:
- Package arbitro_pkg holds:
  - typedef enum logic [1:0] estado_t {OCIOSO, CONCEDE, TROCA}
  - localparam N_ENTRADAS=8
  - localparam SEL_W=3
- Sub-module seletor_prioridade_rr: purely combinational circular priority encoder.
  - Inputs: REQ[7:0] and ptr[2:0].
  - Outputs: indice[2:0] and achou.
  - Unit-testable on its own.
- The FSM, counter and output registers live in arbitro_mux_8x1. Integration: SEL connects directly to mux_8x1_n SEL.

Test Plan:
1. Reset, then REQ=8'h00 for 10 cycles -> GNT=8'h00, SEL=3'b000, VALIDO=0, ESTADO_DB=00 throughout.
2. REQ=8'b0000_0100 at edge k -> at edge k+1 GNT=8'h04, SEL=3'b010, VALIDO=1. Drop REQ -> one cycle GNT=0, VALIDO=0, SEL=010, then OCIOSO.
3. MAX_CICLOS=4, REQ=8'hFF held -> grants in order 0,1,...,7,0. Each grant lasts 4 cycles, separated by one VALIDO=0 cycle; period 40 cycles.
4. Wrap: after a grant to index 7 ends, REQ=8'b1000_0001 -> next grant is index 0 (GNT=8'h01, SEL=000), then index 7.
5. MAX_CICLOS=4, only REQ=8'h08 held for 40 cycles -> GNT=8'h08 continuously, no TROCA, VALIDO never drops.
6. During a grant to index 5, REQ=8'h21, assert reset one cycle -> next edge GNT=0, SEL=000, VALIDO=0. After reset releases, grant goes to index 0 (ptr=0), not index 5.
